// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: peripheral register
// offsets, TCTRL bit positions and the address-decode select type.
package dmem_pkg;

    // Byte offsets of the peripheral registers from MMIO_BASE
    localparam logic [31:0] OFF_GPIO_OUT = 32'h0000_0000;
    localparam logic [31:0] OFF_GPIO_IN  = 32'h0000_0004;
    localparam logic [31:0] OFF_TCNT     = 32'h0000_0008;
    localparam logic [31:0] OFF_TCMP     = 32'h0000_000C;
    localparam logic [31:0] OFF_TCTRL    = 32'h0000_0010;

    // TCTRL bit positions
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_FLAG = 2;
    localparam int TCTRL_IE   = 3;

    // Which region the current address falls into
    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_MMIO = 2'd1,
        SEL_NONE = 2'd2
    } sel_e;

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// 32-bit compare timer: TCNT/TCMP/TCTRL registers, match detection,
// one-shot / auto-reload behaviour and the level interrupt output.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_tcnt,
    input  logic        wr_tcmp,
    input  logic        wr_tctrl,
    input  logic [31:0] wd,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic [3:0]  tctrl,
    output logic        timer_irq
);

    logic [31:0] tcnt_reg, tcnt_next;
    logic [31:0] tcmp_reg, tcmp_next;
    logic        en_reg, en_next;
    logic        auto_reg, auto_next;
    logic        flag_reg, flag_next;
    logic        ie_reg, ie_next;
    logic        match;

    // Next-state: timer action first, core writes override it, match-set beats W1C
    always_comb begin
        match     = en_reg && (tcnt_reg == tcmp_reg);
        tcnt_next = tcnt_reg;
        tcmp_next = tcmp_reg;
        en_next   = en_reg;
        auto_next = auto_reg;
        flag_next = flag_reg;
        ie_next   = ie_reg;

        if (en_reg) begin
            if (match) begin
                if (auto_reg) begin
                    tcnt_next = 32'h0;
                end else begin
                    en_next = 1'b0;
                end
            end else begin
                tcnt_next = tcnt_reg + 32'h1;
            end
        end

        if (wr_tcnt) begin
            tcnt_next = wd;
        end
        if (wr_tcmp) begin
            tcmp_next = wd;
        end
        if (wr_tctrl) begin
            en_next   = wd[TCTRL_EN];
            auto_next = wd[TCTRL_AUTO];
            ie_next   = wd[TCTRL_IE];
            if (wd[TCTRL_FLAG]) begin
                flag_next = 1'b0;
            end
        end
        if (match) begin
            flag_next = 1'b1;
        end
    end

    // Timer state registers, cleared immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_reg <= 32'h0;
            tcmp_reg <= 32'h0;
            en_reg   <= 1'b0;
            auto_reg <= 1'b0;
            flag_reg <= 1'b0;
            ie_reg   <= 1'b0;
        end else begin
            tcnt_reg <= tcnt_next;
            tcmp_reg <= tcmp_next;
            en_reg   <= en_next;
            auto_reg <= auto_next;
            flag_reg <= flag_next;
            ie_reg   <= ie_next;
        end
    end

    // Register views for the read mux and the interrupt level
    always_comb begin
        tctrl             = 4'h0;
        tctrl[TCTRL_EN]   = en_reg;
        tctrl[TCTRL_AUTO] = auto_reg;
        tctrl[TCTRL_FLAG] = flag_reg;
        tctrl[TCTRL_IE]   = ie_reg;
        tcnt              = tcnt_reg;
        tcmp              = tcmp_reg;
        timer_irq         = flag_reg & ie_reg;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus a small
// peripheral window (GPIO out/in and compare timer) with a combinational
// read path so the core sees read data in the same cycle.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [31:0]       a,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [29:0]       word_addr;
    logic [31:0]       off;
    logic [AW-1:0]     ram_idx;
    sel_e              sel;
    logic              mmio_we;
    logic [31:0]       ram_mem [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_reg;
    logic [GPIO_W-1:0] gpio_sync;
    logic [31:0]       tcnt_val;
    logic [31:0]       tcmp_val;
    logic [3:0]        tctrl_val;
    logic              unused_addr_bits;

    // Byte lanes are not supported, so the low address bits are dropped
    assign unused_addr_bits = ^a[1:0];
    assign word_addr        = a[31:2];
    assign off              = {a[31:2], 2'b00} - MMIO_BASE;
    assign ram_idx          = word_addr[AW-1:0];
    assign mmio_we          = we && (sel == SEL_MMIO);

    // Region decode; addresses below MMIO_BASE wrap the offset high and miss
    always_comb begin
        sel = SEL_NONE;
        if (word_addr < 30'(RAM_WORDS)) begin
            sel = SEL_RAM;
        end else if (off <= OFF_TCTRL) begin
            sel = SEL_MMIO;
        end
    end

    // Word RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we && (sel == SEL_RAM)) begin
            ram_mem[ram_idx] <= wd;
        end
    end

    // GPIO output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_reg <= '0;
        end else if (mmio_we && (off == OFF_GPIO_OUT)) begin
            gpio_out_reg <= wd[GPIO_W-1:0];
        end
    end

    assign gpio_out = gpio_out_reg;

    // Two-flop synchronizer per input bit
    genvar gi;
    generate
        for (gi = 0; gi < GPIO_W; gi++) begin : g_sync
            logic [1:0] stage_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stage_reg <= 2'b00;
                end else begin
                    stage_reg <= {stage_reg[0], gpio_in[gi]};
                end
            end
            assign gpio_sync[gi] = stage_reg[1];
        end
    endgenerate

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_tcnt   (mmio_we && (off == OFF_TCNT)),
        .wr_tcmp   (mmio_we && (off == OFF_TCMP)),
        .wr_tctrl  (mmio_we && (off == OFF_TCTRL)),
        .wd        (wd),
        .tcnt      (tcnt_val),
        .tcmp      (tcmp_val),
        .tctrl     (tctrl_val),
        .timer_irq (timer_irq)
    );

    // Zero-latency read mux; narrow fields zero-extended, holes read 0
    always_comb begin
        rd = 32'h0;
        case (sel)
            SEL_RAM: rd = ram_mem[ram_idx];
            SEL_MMIO: begin
                case (off)
                    OFF_GPIO_OUT: rd = 32'(gpio_out_reg);
                    OFF_GPIO_IN:  rd = 32'(gpio_sync);
                    OFF_TCNT:     rd = tcnt_val;
                    OFF_TCMP:     rd = tcmp_val;
                    OFF_TCTRL:    rd = 32'(tctrl_val);
                    default:      rd = 32'h0;
                endcase
            end
            default: rd = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed walk through the main
// scenarios followed by randomized traffic, all scored against a behavioural
// model of the memory map and timer.
module tb_data_mem_responder;

    localparam int          NW     = 64;
    localparam logic [31:0] A_GOUT = 32'h0000_1000;
    localparam logic [31:0] A_GIN  = 32'h0000_1004;
    localparam logic [31:0] A_TCNT = 32'h0000_1008;
    localparam logic [31:0] A_TCMP = 32'h0000_100C;
    localparam logic [31:0] A_TCTL = 32'h0000_1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int n_vec = 0;
    int n_err = 0;
    int n_xact = 0;

    data_mem_responder #(
        .RAM_WORDS (NW),
        .GPIO_W    (8),
        .MMIO_BASE (32'h0000_1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_ram [NW];
    bit          m_valid [NW];
    logic [7:0]  m_gout;
    logic [7:0]  m_hist [$];
    logic [31:0] m_cnt, m_cmp;
    bit          m_en, m_auto, m_flag, m_ie;

    function automatic void model_reset(input bit clear_ram);
        m_gout = 8'h0;
        m_hist.delete();
        m_cnt = 0; m_cmp = 0;
        m_en = 0; m_auto = 0; m_flag = 0; m_ie = 0;
        if (clear_ram) for (int i = 0; i < NW; i++) m_valid[i] = 0;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output bit known,
                                       output logic [31:0] val);
        int unsigned w;
        w = addr >> 2;
        known = 1;
        val = 32'h0;
        if (w < NW) begin
            known = m_valid[w];
            val = m_ram[w];
        end else begin
            case (w << 2)
                A_GOUT: val = {24'h0, m_gout};
                A_GIN:  val = (m_hist.size() == 2) ? {24'h0, m_hist[0]} : 32'h0;
                A_TCNT: val = m_cnt;
                A_TCMP: val = m_cmp;
                A_TCTL: val = {28'h0, m_ie, m_flag, m_auto, m_en};
                default: val = 32'h0;
            endcase
        end
    endfunction

    // One clock edge: the timer acts on its own, then a core write overrides
    function automatic void model_edge(input bit w, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [7:0] gin);
        int unsigned widx;
        bit hit;
        logic [31:0] n_cnt;
        bit n_en, n_flag;
        hit = m_en && (m_cnt == m_cmp);
        n_cnt = m_cnt; n_en = m_en; n_flag = m_flag;
        if (m_en) begin
            if (hit) begin
                n_flag = 1;
                if (m_auto) n_cnt = 0;
                else n_en = 0;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        if (w) begin
            widx = addr >> 2;
            if (widx < NW) begin
                m_ram[widx] = data;
                m_valid[widx] = 1;
            end else begin
                case (widx << 2)
                    A_GOUT: m_gout = data[7:0];
                    A_TCNT: n_cnt = data;
                    A_TCMP: m_cmp = data;
                    A_TCTL: begin
                        n_en = data[0];
                        m_auto = data[1];
                        m_ie = data[3];
                        if (data[2] && !hit) n_flag = 0;
                    end
                    default: ;
                endcase
            end
        end
        m_cnt = n_cnt; m_en = n_en; m_flag = n_flag;
        m_hist.push_back(gin);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle, entered and left at a falling edge
    task automatic xact(input bit w, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] seen);
        bit known;
        logic [31:0] exp;
        we = w; a = addr; wd = data;
        #2;
        model_read(addr, known, exp);
        if (known) check("rd", rd, exp);
        check("gpio_out", {24'h0, gpio_out}, {24'h0, m_gout});
        check("timer_irq", {31'h0, timer_irq}, {31'h0, (m_flag & m_ie)});
        seen = rd;
        n_xact++;
        $display("xact %0d we=%0b a=%h wd=%h rd=%h gpio_out=%h irq=%0b",
                 n_xact, w, addr, data, rd, gpio_out, timer_irq);
        @(posedge clk);
        model_edge(w, addr, data, gpio_in);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [31:0] addr, data;
        bit w;
        int pick;

        reset = 1'b0; we = 0; a = A_TCNT; wd = 0; gpio_in = 8'h0;
        model_reset(1);
        repeat (2) @(negedge clk);
        #2;
        check("rst_rd_tcnt", rd, 32'h0);
        check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // RAM write/read, byte offset ignored, first address past RAM is unmapped
        xact(1, 32'h10, 32'hDEAD_BEEF, s);
        xact(0, 32'h10, 0, s);  check("ram_rd", s, 32'hDEAD_BEEF);
        xact(0, 32'h12, 0, s);  check("ram_rd_unaligned", s, 32'hDEAD_BEEF);
        xact(0, 4 * NW, 0, s);  check("ram_end_unmapped", s, 32'h0);

        // GPIO out truncation and zero-extended readback
        xact(1, A_GOUT, 32'hFFFF_FFA5, s);
        check("gpio_out_a5", {24'h0, gpio_out}, 32'hA5);
        xact(0, A_GOUT, 0, s);  check("gpio_out_rd", s, 32'hA5);

        // GPIO in through the synchronizer: two edges of latency
        gpio_in = 8'h3C;
        xact(0, A_GIN, 0, s);   check("gin_edge0", s, 32'h0);
        xact(0, A_GIN, 0, s);   check("gin_edge1", s, 32'h0);
        xact(0, A_GIN, 0, s);   check("gin_edge2", s, 32'h3C);

        // One-shot: counts 1..5, then flag set, en cleared, TCNT holds
        xact(1, A_TCMP, 32'd5, s);
        xact(1, A_TCTL, 32'h9, s);
        for (int i = 0; i <= 5; i++) begin
            xact(0, A_TCNT, 0, s); check("oneshot_cnt", s, 32'(i));
        end
        check("oneshot_irq", {31'h0, timer_irq}, 32'h1);
        xact(0, A_TCTL, 0, s);  check("oneshot_tctrl", s, 32'hC);
        xact(0, A_TCNT, 0, s);  check("oneshot_hold", s, 32'd5);
        xact(1, A_TCTL, 32'hC, s);
        check("w1c_irq", {31'h0, timer_irq}, 32'h0);

        // Auto-reload 0,1,2,3,0,...
        xact(1, A_TCNT, 32'd0, s);
        xact(1, A_TCMP, 32'd3, s);
        xact(1, A_TCTL, 32'hB, s);
        for (int i = 0; i < 9; i++) begin
            xact(0, A_TCNT, 0, s); check("reload_cnt", s, 32'(i % 4));
        end
        check("reload_irq", {31'h0, timer_irq}, 32'h1);
        xact(1, A_TCTL, 32'hF, s);
        check("reload_w1c", {31'h0, timer_irq}, 32'h0);
        xact(0, A_TCNT, 0, s);  check("pre_match_cnt", s, 32'd2);
        xact(1, A_TCTL, 32'hF, s);
        check("match_beats_w1c", {31'h0, timer_irq}, 32'h1);

        // TCNT write wins over increment; wrap past all-ones
        xact(1, A_TCNT, 32'd100, s);
        xact(0, A_TCNT, 0, s);  check("tcnt_wr_100", s, 32'd100);
        xact(0, A_TCNT, 0, s);  check("tcnt_101", s, 32'd101);
        xact(1, A_TCMP, 32'd2, s);
        xact(1, A_TCNT, 32'hFFFF_FFFF, s);
        xact(0, A_TCNT, 0, s);  check("tcnt_max", s, 32'hFFFF_FFFF);
        xact(0, A_TCNT, 0, s);  check("tcnt_wrap", s, 32'h0);

        // Asynchronous reset in the middle of a cycle
        we = 0; a = A_TCNT; wd = 0;
        #2;
        check("pre_reset_irq", {31'h0, timer_irq}, 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, timer_irq}, 32'h0);
        check("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
        check("async_rst_tcnt", rd, 32'h0);
        model_reset(1);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            gpio_in = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            data = $urandom;
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: addr = ($urandom_range(0, NW - 1) << 2) | $urandom_range(0, 3);
                3: addr = 4 * NW + $urandom_range(0, 15);
                4: addr = A_GOUT;
                5: addr = A_GIN;
                6: begin
                    addr = A_TCNT;
                    data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 12));
                end
                7: begin addr = A_TCMP; data = 32'($urandom_range(0, 12)); end
                8: begin addr = A_TCTL; data = {$urandom_range(0, 255), 4'h0} | 32'($urandom_range(0, 15)); end
                default: addr = 32'h1014 + ($urandom_range(0, 1000) << 2);
            endcase
            xact(w, addr, data, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
